// File: rtl/reg8file_pkg.sv
// Shared types and constants for the reg8file read-side dumper.
package reg8file_pkg;

    typedef enum logic [2:0] {
        IDLE, SEL, LOAD, START, DATA, STOP, DONE
    } state_t;

    localparam int FRAME_BITS       = 10;
    localparam int DATA_BITS        = 8;
    localparam int DEF_CLKS_PER_BIT = 4;

endpackage

// File: rtl/reg8file_dumper_bit_tick.sv
// Divide-by-CLKS_PER_BIT bit timer; tick marks the last cycle of each serial bit.
module bit_tick
    import reg8file_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT
) (
    input  logic clk,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [15:0] LAST = 16'(CLKS_PER_BIT - 1);

    logic [15:0] cnt;

    always_ff @(posedge clk) begin
        if (!clr)
            cnt <= '0;
        else if (!en || cnt == LAST)
            cnt <= '0;
        else
            cnt <= cnt + 16'd1;
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/reg8file_dumper.sv
// Walks rsel 0..NREG-1, latches each q and shifts it out as an 8N1 frame on tx.
module reg8file_dumper
    import reg8file_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEF_CLKS_PER_BIT,
    parameter int NREG         = 8
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    output logic [2:0] rsel,
    input  logic [7:0] q,
    output logic       tx,
    output logic       busy,
    output logic       done,
    output logic [2:0] cur_idx
);

    localparam logic [2:0] LAST_IDX = 3'(NREG - 1);
    localparam logic [2:0] LAST_BIT = 3'(DATA_BITS - 1);

    state_t     state, nxt;
    logic [2:0] idx;
    logic [2:0] bitcnt;
    logic [7:0] shift;
    logic       tick;
    logic       en;

    assign en = (state == START) || (state == DATA) || (state == STOP);

    bit_tick #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_tick (
        .clk  (clk),
        .clr  (clr),
        .en   (en),
        .tick (tick)
    );

    always_ff @(posedge clk) begin
        if (!clr)
            state <= IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt = state;
        case (state)
            IDLE:    if (start) nxt = SEL;
            SEL:     nxt = LOAD;
            LOAD:    nxt = START;
            START:   if (tick) nxt = DATA;
            DATA:    if (tick && bitcnt == LAST_BIT) nxt = STOP;
            STOP:    if (tick) nxt = (idx == LAST_IDX) ? DONE : SEL;
            DONE:    nxt = IDLE;
            default: nxt = IDLE;
        endcase
    end

    // rsel is registered out of SEL so q has all of LOAD to settle before capture
    always_ff @(posedge clk) begin
        if (!clr) begin
            idx    <= '0;
            rsel   <= '0;
            bitcnt <= '0;
            shift  <= '0;
        end else begin
            case (state)
                IDLE: if (start) begin
                    idx  <= '0;
                    rsel <= '0;
                end
                SEL:  rsel <= idx;
                LOAD: begin
                    shift  <= q;
                    bitcnt <= '0;
                end
                DATA: if (tick) begin
                    shift  <= {1'b0, shift[7:1]};
                    bitcnt <= bitcnt + 3'd1;
                end
                STOP: if (tick && idx != LAST_IDX) idx <= idx + 3'd1;
                default: ;
            endcase
        end
    end

    always_comb begin
        tx   = 1'b1;
        busy = 1'b0;
        done = 1'b0;
        case (state)
            SEL, LOAD, STOP: busy = 1'b1;
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
            end
            DATA: begin
                tx   = shift[0];
                busy = 1'b1;
            end
            DONE:    done = 1'b1;
            default: ;
        endcase
    end

    assign cur_idx = idx;

endmodule

// File: tb/tb_reg8file_dumper.sv
// Directed bench: two dumper instances (4 and 1 clocks per bit) reading a modelled reg8file.
module tb_reg8file_dumper;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [7:0] regs [8];

    logic       clr4, start4, tx4, busy4, done4;
    logic [2:0] rsel4, cur4;
    logic [7:0] q4;
    logic       clr1, start1, tx1, busy1, done1;
    logic [2:0] rsel1, cur1;
    logic [7:0] q1;

    assign q4 = regs[rsel4];
    assign q1 = regs[rsel1];

    reg8file_dumper #(.CLKS_PER_BIT(4), .NREG(8)) dut4 (
        .clk(clk), .clr(clr4), .start(start4), .rsel(rsel4), .q(q4),
        .tx(tx4), .busy(busy4), .done(done4), .cur_idx(cur4)
    );

    reg8file_dumper #(.CLKS_PER_BIT(1), .NREG(8)) dut1 (
        .clk(clk), .clr(clr1), .start(start1), .rsel(rsel1), .q(q1),
        .tx(tx1), .busy(busy1), .done(done1), .cur_idx(cur1)
    );

    typedef struct {
        int          inst;      // 0: 4 clks/bit, 1: 1 clk/bit
        logic [63:0] data;      // reg i = data[8*i +: 8]
        int          again;     // sample index at which a stray start pulse is issued, -1 none
        int          exp_busy;
    } vec_t;

    vec_t vecs [4];

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic       tr [$];
    logic       busy_tr [$];
    logic       done_tr [$];
    logic [7:0] frames [$];
    int         done_cnt, busy_cnt, width_err, stop_err, nsamp;

    task automatic chk(input string nm, input int act, input int exp);
        tot_cnt++;
        if (act == exp) pass_cnt++;
        else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    endtask

    function automatic logic o_tx(input int inst);
        return (inst != 0) ? tx1 : tx4;
    endfunction

    function automatic logic o_busy(input int inst);
        return (inst != 0) ? busy1 : busy4;
    endfunction

    function automatic logic o_done(input int inst);
        return (inst != 0) ? done1 : done4;
    endfunction

    task automatic set_start(input int inst, input logic v);
        if (inst != 0) start1 = v;
        else start4 = v;
    endtask

    task automatic load_regs(input logic [63:0] d);
        for (int i = 0; i < 8; i++) regs[i] = d[8*i +: 8];
    endtask

    // Caller is at a negedge; records one sample per cycle until ndone done pulses plus one more cycle.
    task automatic run_dump(input int inst, input int again, input int ndone, input bit hold);
        int n;
        n = 0;
        tr.delete(); busy_tr.delete(); done_tr.delete();
        done_cnt = 0; busy_cnt = 0;
        set_start(inst, 1'b1);
        while (done_cnt < ndone && n < 3000) begin
            @(negedge clk);
            tr.push_back(o_tx(inst));
            busy_tr.push_back(o_busy(inst));
            done_tr.push_back(o_done(inst));
            if (o_busy(inst)) busy_cnt++;
            if (o_done(inst)) done_cnt++;
            n++;
            set_start(inst, hold || (n == again));
        end
        chk("dump_in_time", int'(n < 3000), 1);
        @(negedge clk);
        tr.push_back(o_tx(inst));
        busy_tr.push_back(o_busy(inst));
        done_tr.push_back(o_done(inst));
        if (o_done(inst)) done_cnt++;
        set_start(inst, 1'b0);
        nsamp = n + 1;
    endtask

    // Every cycle of every bit time must carry the same level.
    task automatic decode(input int cpb);
        int i;
        logic [7:0] b;
        frames.delete();
        width_err = 0;
        stop_err  = 0;
        i = 0;
        while (i < tr.size()) begin
            if (tr[i] == 1'b0 && i + 10*cpb <= tr.size()) begin
                b = '0;
                for (int k = 0; k < 10; k++) begin
                    for (int c = 0; c < cpb; c++) begin
                        if (k == 0) begin
                            if (tr[i + c] != 1'b0) width_err++;
                        end else if (k == 9) begin
                            if (tr[i + 9*cpb + c] != 1'b1) stop_err++;
                        end else if (c == 0) begin
                            b[k-1] = tr[i + k*cpb];
                        end else if (tr[i + k*cpb + c] != b[k-1]) begin
                            width_err++;
                        end
                    end
                end
                frames.push_back(b);
                i += 10*cpb;
            end else begin
                i++;
            end
        end
    endtask

    task automatic chk_frames(input string nm, input int nexp);
        chk({nm, "_nframes"}, frames.size(), nexp);
        for (int i = 0; i < nexp; i++)
            chk($sformatf("%s_frame%0d", nm, i),
                (i < frames.size()) ? int'(frames[i]) : -1, int'(regs[i % 8]));
        chk({nm, "_width"}, width_err, 0);
        chk({nm, "_stop"},  stop_err,  0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        int d, n;
        vecs[0] = '{0, 64'h0706050403020100, -1, 336};
        vecs[1] = '{0, 64'h0180FF5AA5332211, 100, 336};
        vecs[2] = '{1, 64'h0706050403020100, -1, 96};
        vecs[3] = '{1, 64'h3C0F9681A5C3E77E, 30, 96};

        clr4 = 1'b0; clr1 = 1'b0; start4 = 1'b0; start1 = 1'b0;
        load_regs(vecs[0].data);
        repeat (3) @(negedge clk);

        chk("rst_tx",    tx4,   1);
        chk("rst_busy",  busy4, 0);
        chk("rst_done",  done4, 0);
        chk("rst_rsel",  rsel4, 0);
        chk("rst_idx",   cur4,  0);
        chk("rst1_tx",   tx1,   1);
        chk("rst1_busy", busy1, 0);
        clr4 = 1'b1; clr1 = 1'b1;
        @(negedge clk);

        for (int v = 0; v < 4; v++) begin
            load_regs(vecs[v].data);
            run_dump(vecs[v].inst, vecs[v].again, 1, 1'b0);
            decode(vecs[v].inst != 0 ? 1 : 4);
            chk_frames($sformatf("v%0d", v), 8);
            chk($sformatf("v%0d_busy", v), busy_cnt, vecs[v].exp_busy);
            chk($sformatf("v%0d_done", v), done_cnt, 1);
            repeat (2) @(negedge clk);
        end

        // Reset in the middle of data bit 4 of frame 2
        load_regs(vecs[0].data);
        start4 = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            start4 = 1'b0;
            n++;
        end while (!(cur4 == 3'd2 && tx4 == 1'b0) && n < 1000);
        chk("mid_reach_frame2", int'(n < 1000), 1);
        repeat (20) @(negedge clk);
        chk("mid_still_busy", busy4, 1);
        clr4 = 1'b0;
        @(negedge clk);
        chk("mid_rst_tx",   tx4,   1);
        chk("mid_rst_busy", busy4, 0);
        chk("mid_rst_rsel", rsel4, 0);
        chk("mid_rst_idx",  cur4,  0);
        clr4 = 1'b1;
        repeat (2) @(negedge clk);
        chk("mid_rst_idle_tx", tx4, 1);
        run_dump(0, -1, 1, 1'b0);
        decode(4);
        chk_frames("after_rst", 8);
        chk("after_rst_busy", busy_cnt, 336);
        repeat (2) @(negedge clk);

        // start held high: back-to-back dumps with one IDLE cycle between
        load_regs(vecs[1].data);
        run_dump(0, -1, 2, 1'b1);
        decode(4);
        chk_frames("held", 16);
        chk("held_busy", busy_cnt, 672);
        chk("held_done", done_cnt, 2);
        d = -1;
        for (int i = 0; i < done_tr.size(); i++)
            if (d < 0 && done_tr[i]) d = i;
        chk("held_done_found", int'(d >= 0 && d + 2 < nsamp), 1);
        if (d >= 0 && d + 2 < nsamp) begin
            chk("held_gap_idle", busy_tr[d+1], 0);
            chk("held_gap_sel",  busy_tr[d+2], 1);
        end
        repeat (2) @(negedge clk);

        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/reg8file_dumper.md
Name: reg8file_dumper

Overview:
- Read-side master for the 8x8 register file (reg8file).
- On a start pulse, walks rsel from 0 to 7 and captures each q value.
- Sends each captured byte out on a single serial line as an 8N1-style frame (start bit, 8 data bits LSB-first, stop bit).
- Used to dump register-file contents to a host or logic analyser. It is the reader that pairs with the register-file write sequence.

Parameters:
- CLKS_PER_BIT, default 4: clk cycles per serial bit. Legal range is 1..65535.
- NREG, default 8: number of registers dumped, starting at index 0. Fixed at 8 for reg8file.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- clr  input  1  synchronous, active-low reset. Sampled only on the clk rising edge; clr=0 resets the block.
- start  input  1  dump request. Sampled only in IDLE.
- rsel  output  3  read select driven to reg8file.
- q  input  8  read data from reg8file. Combinational function of rsel.
- tx  output  1  serial output; idles high.
- busy  output  1  high while a dump is in progress.
- done  output  1  one-cycle pulse after the last stop bit of register NREG-1.
- cur_idx  output  3  index of the register currently being sent, for debug and LEDs.

Behaviour:
- Reset (clr=0 at an edge): state=IDLE, tx=1, busy=0, done=0, rsel=0, cur_idx=0, bit counter=0, tick counter=0, shift register=0.
  - Applies from any state, including mid-frame. tx returns to 1 at that same edge.
  - No partial frame is resumed after reset.
- IDLE: tx=1, busy=0. If start=1, go to SEL, set idx=0 and rsel=0. Otherwise stay.
- SEL (1 cycle): rsel=idx, which gives q one full cycle to settle. Then go to LOAD.
- LOAD (1 cycle): shift register <= q, then go to START.
- START: tx=0 for CLKS_PER_BIT cycles, then go to DATA.
- DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shifting right after each bit. After 8 bits, go to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles.
  - If idx < NREG-1: idx++, go to SEL.
  - Otherwise go to DONE.
- DONE (1 cycle): done=1, busy=0, tx=1. Then go to IDLE.
- busy=1 in SEL, LOAD, START, DATA and STOP.
- Busy duration per dump: NREG*(2 + 10*CLKS_PER_BIT) cycles. With defaults this is 336 cycles.
- Between consecutive frames tx stays 1 for 2 extra cycles (SEL and LOAD), so the inter-frame idle is CLKS_PER_BIT+2 cycles.
- start while busy or in DONE is ignored and not queued. start held high continuously gives back-to-back dumps with exactly one IDLE cycle between DONE and SEL.
- rsel holds its value outside SEL/LOAD. Changes to q after LOAD do not affect the frame in flight.
- Tick counter is 16-bit. It wraps to 0 at CLKS_PER_BIT-1 and marks a bit boundary. With CLKS_PER_BIT=1, every cycle is a bit boundary.
- idx wrap: no wrap. The dump terminates at NREG-1.

Decomposition:
- Package reg8file_pkg holds:
  - state enum {IDLE, SEL, LOAD, START, DATA, STOP, DONE}
  - FRAME_BITS=10, DATA_BITS=8
  - default CLKS_PER_BIT.
- One sub-module, bit_tick: parameterised divide-by-CLKS_PER_BIT counter.
  - Inputs: clk, clr, en.
  - Output: tick, a one-cycle pulse when the count reaches CLKS_PER_BIT-1.
  - Counter clears when en=0.

Test Plan:
- Preload reg8file with regs 0..7 = 0x00..0x07, pulse start for 1 cycle, CLKS_PER_BIT=4 -> decoded tx frames are 0x00..0x07 in order, stop bits all 1; busy high for 336 cycles; done high exactly 1 cycle.
- Reg3 = 0xA5 -> frame 3 data bits on tx are 1,0,1,0,0,1,0,1. Each bit lasts 4 cycles; start bit 0, stop bit 1.
- Pulse start again at cycle 100 of a dump -> no effect. Exactly 8 frames, one done pulse.
- Drive clr=0 during DATA bit 4 of frame 2 -> next edge tx=1, busy=0, rsel=0, cur_idx=0. A new start then produces a full 8-frame dump from reg 0.
- CLKS_PER_BIT=1 -> each frame is 10 cycles, busy lasts 8*12=96 cycles, data still correct.
- start held at 1 -> two dumps separated by DONE plus one IDLE cycle. Second dump's tx matches the first.
